// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pipelined sync and colour alignment
//
// Optional feature macro: VGA_TEST_PATTERN_EN
//   When defined, adds input itest_en and an eight-vertical-bar colour pattern.
//
// Ports:
//   iclock        in   1        sole clock, rising edge
//   ireset        in   1        synchronous active-high reset
//   ipix_en       in   1        pixel-rate enable; all state advances only when 1
//   ipix_r/g/b    in   COLOR_W  colour for the coordinate presented PIPE enabled cycles earlier
//   itest_en      in   1        (VGA_TEST_PATTERN_EN only) replace colour with bar pattern
//   ohcount       out  CNT_W    current horizontal coordinate
//   ovcount       out  CNT_W    current vertical coordinate
//   oreq          out  1        current coordinate lies in the active region
//   ovga_r/g/b    out  COLOR_W  registered colour outputs
//   ohsync        out  1        registered horizontal sync, asserted level SYNC_POL
//   ovsync        out  1        registered vertical sync, asserted level SYNC_POL
//   oframe_start  out  1        one-cycle pulse after the enabled cycle that wraps both counters

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int COLOR_W  = 1,
  parameter int PIPE     = 2,
  parameter int CNT_W    = 11
) (
  input  logic               iclock,
  input  logic               ireset,
  input  logic               ipix_en,
  input  logic [COLOR_W-1:0] ipix_r,
  input  logic [COLOR_W-1:0] ipix_g,
  input  logic [COLOR_W-1:0] ipix_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               itest_en,
`endif
  output logic [CNT_W-1:0]   ohcount,
  output logic [CNT_W-1:0]   ovcount,
  output logic               oreq,
  output logic [COLOR_W-1:0] ovga_r,
  output logic [COLOR_W-1:0] ovga_g,
  output logic [COLOR_W-1:0] ovga_b,
  output logic               ohsync,
  output logic               ovsync,
  output logic               oframe_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  // ---------------------------------------------------------------------------
  // Coordinate counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
  logic             h_last;
  logic             v_last;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  always_ff @(posedge iclock) begin
    if (ireset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (ipix_en) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : (vcount + CNT_ONE);
      end else begin
        hcount <= hcount + CNT_ONE;
      end
    end
  end

  assign ohcount = hcount;
  assign ovcount = vcount;

  // ---------------------------------------------------------------------------
  // Raw decode of the counter registers (active-high internally)
  // ---------------------------------------------------------------------------
  logic hs_raw;
  logic vs_raw;

  assign oreq   = (hcount < H_ACT) && (vcount < V_ACT);
  assign hs_raw = (hcount >= HS_START) && (hcount < HS_END);
  assign vs_raw = (vcount >= VS_START) && (vcount < VS_END);

  // ---------------------------------------------------------------------------
  // PIPE-stage delay line; stage PIPE-1 lines up with the colour that the
  // pixel source returns PIPE enabled cycles after seeing the coordinate.
  // ---------------------------------------------------------------------------
  logic [PIPE-1:0] req_dl;
  logic [PIPE-1:0] hs_dl;
  logic [PIPE-1:0] vs_dl;

  always_ff @(posedge iclock) begin
    if (ireset) begin
      req_dl <= '0;
      hs_dl  <= '0;
      vs_dl  <= '0;
    end else if (ipix_en) begin
      req_dl[0] <= oreq;
      hs_dl[0]  <= hs_raw;
      vs_dl[0]  <= vs_raw;
      for (int i = 1; i < PIPE; i++) begin
        req_dl[i] <= req_dl[i-1];
        hs_dl[i]  <= hs_dl[i-1];
        vs_dl[i]  <= vs_dl[i-1];
      end
    end
  end

  logic req_d;
  logic hs_d;
  logic vs_d;

  assign req_d = req_dl[PIPE-1];
  assign hs_d  = hs_dl[PIPE-1];
  assign vs_d  = vs_dl[PIPE-1];

  // ---------------------------------------------------------------------------
  // Colour source selection
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] sel_r;
  logic [COLOR_W-1:0] sel_g;
  logic [COLOR_W-1:0] sel_b;

`ifdef VGA_TEST_PATTERN_EN
  // The bar pattern needs the horizontal coordinate aligned with req_d, so
  // hcount travels down its own copy of the delay line.
  localparam int               BAR_W   = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;
  localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

  logic [CNT_W-1:0] hc_dl [PIPE];
  logic [2:0]       bar_k;

  always_ff @(posedge iclock) begin
    if (ireset) begin
      for (int i = 0; i < PIPE; i++) begin
        hc_dl[i] <= '0;
      end
    end else if (ipix_en) begin
      hc_dl[0] <= hcount;
      for (int i = 1; i < PIPE; i++) begin
        hc_dl[i] <= hc_dl[i-1];
      end
    end
  end

  // Only the low three bits of the bar index are meaningful inside the
  // active region (eight bars).
  assign bar_k = 3'(hc_dl[PIPE-1] / BAR_W_C);

  always_comb begin
    sel_r = ipix_r;
    sel_g = ipix_g;
    sel_b = ipix_b;
    if (itest_en) begin
      sel_r = {COLOR_W{bar_k[2]}};
      sel_g = {COLOR_W{bar_k[1]}};
      sel_b = {COLOR_W{bar_k[0]}};
    end
  end
`else
  assign sel_r = ipix_r;
  assign sel_g = ipix_g;
  assign sel_b = ipix_b;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iclock) begin
    if (ireset) begin
      ovga_r       <= '0;
      ovga_g       <= '0;
      ovga_b       <= '0;
      ohsync       <= ~SYNC_ON;
      ovsync       <= ~SYNC_ON;
      oframe_start <= 1'b0;
    end else begin
      // Pulse is a single iclock cycle even if the next cycle is disabled.
      oframe_start <= ipix_en && h_last && v_last;
      if (ipix_en) begin
        ovga_r <= req_d ? sel_r : '0;
        ovga_g <= req_d ? sel_g : '0;
        ovga_b <= req_d ? sel_b : '0;
        ohsync <= hs_d ? SYNC_ON : ~SYNC_ON;
        ovsync <= vs_d ? SYNC_ON : ~SYNC_ON;
      end
    end
  end

endmodule
